// File: rtl/mssd_param.sv
// mssd_param - parametrised multi-channel serial demultiplexer.
//
// Frame on serIn (idle 1): start(0) | addr[ADDR_W] | len[LEN_W] | payload[L+1]
//                          | parity (MSSD_PARITY_EN only) | stop(1)
// Each payload bit is presented on dout with a one-hot ch_sel and out_valid.
// Frames addressed at a channel >= NCH are consumed silently after one error.
//
// Optional feature macro: MSSD_PARITY_EN - adds an even-parity bit after the
// payload, checked against the XOR of the payload bits.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   serIn      serial input
//   dout       current payload bit (registered)
//   ch_sel     one-hot channel of dout, zero when out_valid=0
//   out_valid  dout/ch_sel valid
//   frame_done one-cycle pulse after a clean frame's good stop bit
//   error      one-cycle pulse per detected fault
//   busy       high whenever the receiver is not idle
//
// state  | meaning
// -------+---------------------------------------------
// S_IDLE | waiting for start bit
// S_ADDR | shifting in channel address, MSB first
// S_LEN  | shifting in length field into payload counter
// S_DATA | forwarding payload bits, counter counts down
// S_PAR  | sampling parity bit (MSSD_PARITY_EN only)
// S_STOP | sampling stop bit
module mssd_param #(
    parameter int ADDR_W = 2,
    parameter int NCH    = 4,
    parameter int LEN_W  = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           serIn,
    output logic           dout,
    output logic [NCH-1:0] ch_sel,
    output logic           out_valid,
    output logic           frame_done,
    output logic           error,
    output logic           busy
);

    localparam int CNT_MAX = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [LEN_W-1:0]  r_bcnt, w_bcnt_nxt;
    logic              r_drop, w_drop_nxt;
    logic              r_ferr, w_ferr_nxt;
    logic              r_dout, w_dout_nxt;
    logic [NCH-1:0]    r_sel, w_sel_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_done, w_done_nxt;
    logic              r_err, w_err_nxt;
`ifdef MSSD_PARITY_EN
    logic              r_par, w_par_nxt;
`endif

    // Shift-in values; truncating casts keep this valid for 1-bit fields.
    logic [ADDR_W-1:0] w_addr_sh;
    logic [LEN_W-1:0]  w_len_sh;
    assign w_addr_sh = ADDR_W'({r_addr, serIn});
    assign w_len_sh  = LEN_W'({r_bcnt, serIn});

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_addr_nxt  = r_addr;
        w_bcnt_nxt  = r_bcnt;
        w_drop_nxt  = r_drop;
        w_ferr_nxt  = r_ferr;
        w_dout_nxt  = r_dout;
        w_sel_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
`ifdef MSSD_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (!serIn) begin
                    w_state_nxt = S_ADDR;
                    w_cnt_nxt   = CW'(ADDR_W - 1);
                    w_addr_nxt  = '0;
                    w_drop_nxt  = 1'b0;
                    w_ferr_nxt  = 1'b0;
`ifdef MSSD_PARITY_EN
                    w_par_nxt   = 1'b0;
`endif
                end
            end
            S_ADDR: begin
                w_addr_nxt = w_addr_sh;
                if (r_cnt == '0) begin
                    w_state_nxt = S_LEN;
                    w_cnt_nxt   = CW'(LEN_W - 1);
                    if (int'(w_addr_sh) >= NCH) begin
                        w_drop_nxt = 1'b1;
                        w_ferr_nxt = 1'b1;
                        w_err_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_LEN: begin
                // Length shifts straight into the payload down-counter.
                w_bcnt_nxt = w_len_sh;
                if (r_cnt == '0) w_state_nxt = S_DATA;
                else             w_cnt_nxt   = r_cnt - 1'b1;
            end
            S_DATA: begin
`ifdef MSSD_PARITY_EN
                w_par_nxt = r_par ^ serIn;
`endif
                if (!r_drop) begin
                    w_dout_nxt  = serIn;
                    w_sel_nxt   = NCH'(1) << r_addr;
                    w_valid_nxt = 1'b1;
                end
                // Terminal count at zero: L=all-ones yields 2**LEN_W bits.
                if (r_bcnt == '0) begin
`ifdef MSSD_PARITY_EN
                    w_state_nxt = S_PAR;
`else
                    w_state_nxt = S_STOP;
`endif
                end else begin
                    w_bcnt_nxt = r_bcnt - 1'b1;
                end
            end
`ifdef MSSD_PARITY_EN
            S_PAR: begin
                if (serIn != r_par) begin
                    w_err_nxt  = 1'b1;
                    w_ferr_nxt = 1'b1;
                end
                w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                if (serIn) w_done_nxt = !r_ferr;
                else       w_err_nxt  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_bcnt  <= '0;
            r_drop  <= 1'b0;
            r_ferr  <= 1'b0;
            r_dout  <= 1'b0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef MSSD_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_bcnt  <= w_bcnt_nxt;
            r_drop  <= w_drop_nxt;
            r_ferr  <= w_ferr_nxt;
            r_dout  <= w_dout_nxt;
            r_sel   <= w_sel_nxt;
            r_valid <= w_valid_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
`ifdef MSSD_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end

    assign dout       = r_dout;
    assign ch_sel     = r_sel;
    assign out_valid  = r_valid;
    assign frame_done = r_done;
    assign error      = r_err;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_mssd_param.sv
// Testbench for mssd_param: two instances share one serial stream, one with
// the default NCH=4 and one with NCH=3, each checked cycle by cycle against
// expectations derived from the frame description.
module tb_mssd_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       serIn;
    logic       dout4, valid4, done4, err4, busy4;
    logic [3:0] sel4;
    logic       dout3, valid3, done3, err3, busy3;
    logic [2:0] sel3;

    always #5 clk = ~clk;

    mssd_param #(.ADDR_W(2), .NCH(4), .LEN_W(4)) u_dut (
        .clk(clk), .rst(rst), .serIn(serIn), .dout(dout4), .ch_sel(sel4),
        .out_valid(valid4), .frame_done(done4), .error(err4), .busy(busy4));

    mssd_param #(.ADDR_W(2), .NCH(3), .LEN_W(4)) u_dut3 (
        .clk(clk), .rst(rst), .serIn(serIn), .dout(dout3), .ch_sel(sel3),
        .out_valid(valid3), .frame_done(done3), .error(err3), .busy(busy3));

    typedef struct {
        bit         v;
        bit         d;
        logic [3:0] sel;
        bit         done;
        bit         err;
        bit         busy;
    } exp_t;

    typedef struct {
        int          addr;
        int          len;
        logic [15:0] pay;
        bit          stop;
        int          gap;
        int          nv4, nd4, ne4;
        int          nv3, nd3, ne3;
    } vec_t;

    int checks   = 0;
    int failures = 0;
    int par_req  = 0;
    int obs_v[2], obs_d[2], obs_e[2];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t blank(input bit b);
        exp_t e;
        e.v = 0; e.d = 0; e.sel = 4'b0; e.done = 0; e.err = 0; e.busy = b;
        return e;
    endfunction

    // Drive one bit, then compare both instances after the sampling edge.
    task automatic run_bit(input bit b, input exp_t e4, input exp_t e3);
        @(negedge clk);
        serIn = b;
        @(posedge clk);
        #1;
        chk("valid4", int'(valid4), int'(e4.v));
        chk("sel4",   int'(sel4),   int'(e4.sel));
        chk("done4",  int'(done4),  int'(e4.done));
        chk("err4",   int'(err4),   int'(e4.err));
        chk("busy4",  int'(busy4),  int'(e4.busy));
        if (e4.v) chk("dout4", int'(dout4), int'(e4.d));
        chk("valid3", int'(valid3), int'(e3.v));
        chk("sel3",   int'(sel3),   int'(e3.sel[2:0]));
        chk("done3",  int'(done3),  int'(e3.done));
        chk("err3",   int'(err3),   int'(e3.err));
        chk("busy3",  int'(busy3),  int'(e3.busy));
        if (e3.v) chk("dout3", int'(dout3), int'(e3.d));
        obs_v[0] += int'(valid4); obs_d[0] += int'(done4); obs_e[0] += int'(err4);
        obs_v[1] += int'(valid3); obs_d[1] += int'(done3); obs_e[1] += int'(err3);
    endtask

    // Reference: expected outputs follow directly from the frame's fields.
    task automatic send_frame(input int addr, input int len, input logic [15:0] pay,
                              input bit par_wrong, input bit stop, input int gap);
        int   nch[2];
        bit   drop[2];
        exp_t e[2];
        bit   b;
        bit   x;
        bit   perr;
        nch[0] = 4; nch[1] = 3;
        x = 0; perr = 0;
        for (int m = 0; m < 2; m++) begin
            drop[m] = (addr >= nch[m]);
            obs_v[m] = 0; obs_d[m] = 0; obs_e[m] = 0;
        end
        for (int g = 0; g < gap; g++) run_bit(1'b1, blank(0), blank(0));
        run_bit(1'b0, blank(1), blank(1));
        for (int i = 1; i >= 0; i--) begin
            b = addr[i];
            for (int m = 0; m < 2; m++) begin
                e[m] = blank(1);
                if (i == 0) e[m].err = drop[m];
            end
            run_bit(b, e[0], e[1]);
        end
        for (int i = 3; i >= 0; i--) begin
            b = len[i];
            run_bit(b, blank(1), blank(1));
        end
        for (int i = 0; i <= len; i++) begin
            b = pay[i];
            x ^= b;
            for (int m = 0; m < 2; m++) begin
                e[m] = blank(1);
                if (!drop[m]) begin
                    e[m].v = 1; e[m].d = b; e[m].sel = 4'(1 << addr);
                end
            end
            run_bit(b, e[0], e[1]);
        end
`ifdef MSSD_PARITY_EN
        perr = par_wrong;
        b = x ^ par_wrong;
        for (int m = 0; m < 2; m++) begin
            e[m] = blank(1);
            e[m].err = perr;
        end
        run_bit(b, e[0], e[1]);
`else
        if (par_wrong) par_req++;
`endif
        for (int m = 0; m < 2; m++) begin
            e[m] = blank(0);
            e[m].done = stop && !drop[m] && !perr;
            e[m].err  = !stop;
        end
        run_bit(stop, e[0], e[1]);
    endtask

    vec_t tbl[6];

    initial begin
        // addr len pay stop gap | nv4 nd4 ne4 | nv3 nd3 ne3
        tbl[0] = '{1, 3,  16'h000D, 1'b1, 3,  4, 1, 0,  4, 1, 0};
        tbl[1] = '{3, 0,  16'h0001, 1'b0, 2,  1, 0, 1,  0, 0, 2};
        tbl[2] = '{3, 1,  16'h0002, 1'b1, 1,  2, 1, 0,  0, 0, 1};
        tbl[3] = '{0, 1,  16'h0001, 1'b1, 0,  2, 1, 0,  2, 1, 0};
        tbl[4] = '{0, 15, 16'hA5C3, 1'b1, 1, 16, 1, 0, 16, 1, 0};
        tbl[5] = '{2, 2,  16'h0005, 1'b1, 0,  3, 1, 0,  3, 1, 0};

        rst = 1'b1;
        serIn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(valid4), 0);
        chk("rst_sel",   int'(sel4),   0);
        chk("rst_dout",  int'(dout4),  0);
        chk("rst_done",  int'(done4),  0);
        chk("rst_err",   int'(err4),   0);
        chk("rst_busy",  int'(busy4),  0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 6; k++) begin
            send_frame(tbl[k].addr, tbl[k].len, tbl[k].pay, 1'b0, tbl[k].stop, tbl[k].gap);
            chk($sformatf("tbl%0d_nv4", k), obs_v[0], tbl[k].nv4);
            chk($sformatf("tbl%0d_nd4", k), obs_d[0], tbl[k].nd4);
            chk($sformatf("tbl%0d_ne4", k), obs_e[0], tbl[k].ne4);
            chk($sformatf("tbl%0d_nv3", k), obs_v[1], tbl[k].nv3);
            chk($sformatf("tbl%0d_nd3", k), obs_d[1], tbl[k].nd3);
            chk($sformatf("tbl%0d_ne3", k), obs_e[1], tbl[k].ne3);
        end

        // Reset in the middle of DATA: start, addr 10, len 0111, 3 payload bits.
        begin
            bit seq[10];
            seq = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                serIn = seq[i];
                @(posedge clk);
            end
            #1;
            chk("mid_valid_pre", int'(valid4), 1);
            chk("mid_busy_pre",  int'(busy4),  1);
            #2;
            rst = 1'b1;
            #1;
            chk("mid_rst_valid", int'(valid4), 0);
            chk("mid_rst_sel",   int'(sel4),   0);
            chk("mid_rst_busy",  int'(busy4),  0);
            chk("mid_rst_err",   int'(err4),   0);
            chk("mid_rst_busy3", int'(busy3),  0);
            chk("mid_rst_val3",  int'(valid3), 0);
            @(negedge clk);
            serIn = 1'b1;
            rst = 1'b0;
            send_frame(1, 3, 16'h000D, 1'b0, 1'b1, 3);
            chk("post_rst_nv", obs_v[0], 4);
            chk("post_rst_nd", obs_d[0], 1);
            chk("post_rst_ne", obs_e[0], 0);
        end

`ifdef MSSD_PARITY_EN
        send_frame(2, 2, 16'h0003, 1'b1, 1'b1, 1);
        chk("par_bad_nv", obs_v[0], 3);
        chk("par_bad_ne", obs_e[0], 1);
        chk("par_bad_nd", obs_d[0], 0);
        send_frame(2, 2, 16'h0003, 1'b0, 1'b1, 1);
        chk("par_ok_nv", obs_v[0], 3);
        chk("par_ok_ne", obs_e[0], 0);
        chk("par_ok_nd", obs_d[0], 1);
`endif

        for (int r = 0; r < 60; r++) begin
            int          a, l, g;
            logic [15:0] p;
            bit          s, pw;
            a  = int'($urandom_range(0, 3));
            l  = int'($urandom_range(0, 15));
            p  = 16'($urandom());
            s  = ($urandom_range(0, 7) != 0);
            pw = ($urandom_range(0, 3) == 0);
            g  = int'($urandom_range(0, 2));
            send_frame(a, l, p, pw, s, g);
        end

        for (int g = 0; g < 3; g++) run_bit(1'b1, blank(0), blank(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mssd_param.md
Name: mssd_param

Overview:
- Parametrised multi-channel serial demultiplexer, successor to the fixed 4-channel MSSD.
- Receives framed bit-serial input: start bit, channel address, length field, payload, optional parity, stop bit.
- Steers each payload bit to a one-hot channel select with a valid strobe.
- Flags framing, address and parity faults; sits between the serial link front end and per-channel collectors.

Parameters:
- ADDR_W, 2, width of the channel address field (MSB first).
- NCH, 4, number of implemented channels; 1 <= NCH <= 2**ADDR_W.
- LEN_W, 4, width of the length field L; payload = L+1 bits (1..2**LEN_W).

Ports:
- clk  in  1  system clock; all sampling on rising edge.
- rst  in  1  asynchronous, active-high reset.
- serIn  in  1  serial input; idle level 1.
- dout  out  1  current payload bit (registered).
- ch_sel  out  NCH  one-hot channel of dout; all zero when out_valid=0.
- out_valid  out  1  dout/ch_sel valid this cycle.
- frame_done  out  1  one-cycle pulse after a frame's stop bit is sampled as 1 with no error in that frame.
- error  out  1  one-cycle pulse per detected fault.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: async to IDLE. dout=0, ch_sel=0, out_valid=0, frame_done=0, error=0, busy=0. Address, length and bit counters cleared. Reset mid-frame abandons the frame with no error pulse.
- All outputs are registered; response to a bit sampled at edge k is visible after edge k, during the following cycle.
- IDLE: serIn=1 stays. serIn=0 is the start bit -> ADDR.
- ADDR: shift in ADDR_W bits MSB first -> LEN.
  - If the address is >= NCH: error pulses in the cycle after the last address bit. The frame is marked dropped and is still fully consumed.
- LEN: shift in LEN_W bits MSB first -> DATA, with the bit counter loaded to L.
- DATA: each sampled bit drives dout, ch_sel = one-hot(addr) and out_valid=1 for one cycle (suppressed if dropped). Counter decrements.
  - After L+1 bits -> PAR if MSSD_PARITY_EN is defined, else STOP.
  - Back-to-back payload bits give continuous out_valid.
- PAR (feature only): sample the parity bit -> STOP.
- STOP: sample the stop bit.
  - 1: frame_done pulses if there was no error in the frame.
  - 0: error pulses (framing error).
  - Either way -> IDLE.
  - The next start bit may arrive the cycle immediately after the stop bit; no idle gap is required.
- Errors are independent pulses. A dropped frame with a bad stop bit pulses error twice: after the address, and after the stop bit.
- L = all-ones gives 2**LEN_W payload bits; the counter must not wrap early.
- NCH = 2**ADDR_W: the address-range check is never true.

Optional Feature:
- Macro: MSSD_PARITY_EN.
- Defined:
  - One even-parity bit follows the payload.
  - It is checked against the XOR of all payload bits.
  - On mismatch, error pulses in the cycle after the parity bit is sampled; frame_done is then suppressed for that frame.
- Undefined: no PAR state; the stop bit directly follows the payload.

Test Plan:
- Reset then idle 1s, frame 0 | 01 | 0011 | 1,0,1,1 | 1 (parity off), defaults:
  - out_valid high for exactly 4 cycles, ch_sel=0010, dout = 1,0,1,1.
  - frame_done pulses after the stop bit; error stays 0.
- Stop bit sampled as 0 after a 1-bit payload (L=0000) on channel 3:
  - one out_valid with ch_sel=1000.
  - error pulses once, no frame_done, busy falls.
- NCH=3, ADDR_W=2, address 11, L=0001, good stop bit:
  - error pulses right after the address; zero out_valid cycles.
  - frame fully consumed; no frame_done; the next frame to channel 0 is received correctly.
- L=1111, channel 0, then a start bit immediately after the stop bit:
  - 16 consecutive out_valid cycles.
  - the second frame is decoded with no lost bits.
- Assert rst during the DATA state of a frame:
  - all outputs 0 immediately (asynchronously), busy=0, no error.
  - the next well-formed frame decodes normally.
- MSSD_PARITY_EN defined, payload 1,1,0 (L=0010), parity bit 1 (wrong):
  - 3 out_valid cycles, then an error pulse, no frame_done.
  - repeat with parity 0 -> frame_done, no error.
